clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Input side of the 6-digit HH:MM:SS clock: reads two raw push-buttons and lets the user edit the time.
//  - Debounces both buttons and steps through the fields hours -> minutes -> seconds.
//  - Edits a shadow copy of the time, then writes it back to clock_core with a one-cycle load strobe.
//  - Sits between board buttons and clock_core; also feeds a blink mask to the display path.
// PARAMETERS
//  INPUT_HZ     50_000_000  system clock frequency (Hz)
//  DEBOUNCE_MS  20          required stable time of a button level (ms)
//  BLINK_HZ     2           blink rate of the field being edited (full periods/s)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  btn_mode     in   1  raw mode button, asynchronous, active-high
//  btn_inc      in   1  raw increment button, asynchronous, active-high
//  cur_h_tens   in   4  current time from clock_core, BCD; same for cur_h_ones, cur_m_tens, cur_m_ones, cur_s_tens, cur_s_ones
//  set_h_tens   out  4  shadow time to load, BCD; same for set_h_ones, set_m_tens, set_m_ones, set_s_tens, set_s_ones
//  load         out  1  1-cycle strobe: clock_core takes set_* on this cycle
//  set_active   out  1  high while in any SET state (clock_core freezes its count)
//  sel          out  2  edited field: 0 none, 1 hours, 2 minutes, 3 seconds
//  blink        out  1  blink phase; display blanks the selected pair while blink=1
// BEHAVIOUR
//  Interface
//  - Clock is clk; reset is rst, asynchronous and active-high.
//  Reset values
//  - state=RUN, set_* = 0, load=0, set_active=0, sel=0, blink=0.
//  - Debounce counters and blink counter = 0; debounced levels = 0.
//  - Reset mid-edit discards the shadow and raises no load.
//  Button conditioning (per button)
//  - Raw input passes through a 2-FF synchronizer.
//  - DB_CYCLES = INPUT_HZ/1000*DEBOUNCE_MS. A level is accepted after the synchronized input differs
//    from the debounced level for DB_CYCLES consecutive cycles; any glitch restarts the count.
//  - The debounced 0->1 edge makes a 1-cycle press pulse. Latency from a clean raw edge to the pulse
//    is DB_CYCLES+3 cycles. Holding a button does not repeat.
//  State machine (sel encoding in brackets)
//  - RUN(0)   --mode-->  SET_H(1). On this transition the shadow captures cur_*.
//  - SET_H(1) --mode-->  SET_M(2).
//  - SET_M(2) --mode-->  SET_S(3).
//  - SET_S(3) --mode-->  RUN(0). On this transition load=1 for exactly one cycle, with set_* stable.
//  - set_active = (state != RUN), registered; it updates on the same cycle as state.
//  Increment rules (BCD arithmetic only, digits never leave 0-9)
//  - In RUN, inc is ignored.
//  - SET_H: hours +1, 23 -> 00; 09 -> 10; 19 -> 20.
//  - SET_M: minutes +1, 59 -> 00. SET_S: seconds +1, 59 -> 00.
//  - Only the selected pair changes; no carry into other fields.
//  - If mode and inc pulses arrive on the same cycle, mode wins and inc is dropped.
//  Shadow and blink
//  - set_* always shows the shadow; it holds its value in RUN after load.
//  - Blink: counter toggles blink every INPUT_HZ/(2*BLINK_HZ) cycles while set_active=1.
//  - Blink counter is cleared and blink forced 0 in RUN; it restarts from 0 on every field change.
// STRUCTURE
//  - Shared package clock_pkg: state encoding (RUN/SET_H/SET_M/SET_S, 2 bits), HOURS_MAX=23,
//    MIN_SEC_MAX=59, BCD digit width = 4.
//  - One sub-module btn_debounce (synchronizer + debounce + edge pulse, parameter DB_CYCLES),
//    instanced twice. The FSM, BCD incrementers and blink counter live in clock_set_ctrl.
// TESTING (INPUT_HZ=10_000, DEBOUNCE_MS=1 -> DB_CYCLES=10; BLINK_HZ=500 -> toggle every 10 cycles)
//  1 Reset: assert rst mid-SET_M -> all outputs 0 on the asserting edge and sel=0; no load ever seen.
//  2 Bounce: btn_mode toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one transition,
//    DB_CYCLES+3 cycles after the final stable edge.
//  3 Capture/load: cur=12:34:56; mode x4 -> set_*=12:34:56 from the SET_H entry on; one load pulse;
//    sel goes 1,2,3,0.
//  4 Wrap: cur=23:59:59; mode, inc -> hours 00; mode, inc -> minutes 00; mode, inc x3 -> seconds 02;
//    mode -> load with 00:00:02.
//  5 Carry digits: hours 09 +inc -> 10, 19 -> 20; minutes 09 -> 10; other pairs unchanged.
//  6 Collision/blink: mode and inc pulses on the same cycle in SET_H -> SET_M with hours unchanged;
//    blink period 20 cycles in SET states; blink stays 0 in RUN.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, BCD limits and the pair incrementer for the HH:MM:SS clock
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;
  localparam int BCD_W = 4;
  localparam int HOURS_MAX = 23;
  localparam int MIN_SEC_MAX = 59;
  // Increment a two-digit BCD pair, wrapping to 00 after max.
  function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] t, input logic [BCD_W-1:0] o, input int max);
    return (t == BCD_W'(max / 10) && o == BCD_W'(max % 10)) ? '0 :
           (o == BCD_W'(9)) ? {t + BCD_W'(1), BCD_W'(0)} : {t, o + BCD_W'(1)};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debounce and 1-cycle press pulse on the debounced rising edge
module btn_debounce #(
  parameter int DB_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int W = $clog2(DB_CYCLES + 1);
  logic s1, s2, db, db_d;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_d <= 1'b0;
      press <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      db_d <= db;
      press <= db & ~db_d;
      if (s2 == db) cnt <= '0;
      else if (cnt == W'(DB_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time setting for the HH:MM:SS clock; edits a shadow copy and loads it back
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int INPUT_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_h_tens,
  input  logic [3:0] cur_h_ones,
  input  logic [3:0] cur_m_tens,
  input  logic [3:0] cur_m_ones,
  input  logic [3:0] cur_s_tens,
  input  logic [3:0] cur_s_ones,
  output logic [3:0] set_h_tens,
  output logic [3:0] set_h_ones,
  output logic [3:0] set_m_tens,
  output logic [3:0] set_m_ones,
  output logic [3:0] set_s_tens,
  output logic [3:0] set_s_ones,
  output logic       load,
  output logic       set_active,
  output logic [1:0] sel,
  output logic       blink
);
  localparam int DB_CYCLES = INPUT_HZ / 1000 * DEBOUNCE_MS;
  localparam int BL_CYC = INPUT_HZ / (2 * BLINK_HZ);
  localparam int BW = $clog2(BL_CYC + 1);
  state_t state, state_nx;
  logic mode_p, inc_p, inc_ok;
  logic [BW-1:0] bcnt;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(mode_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (.clk(clk), .rst(rst), .btn(btn_inc), .press(inc_p));
  // The 2-bit encoding wraps SET_S back to RUN on its own.
  always_comb begin
    state_nx = mode_p ? state_t'(state + 2'd1) : state;
    inc_ok = inc_p & ~mode_p;
  end
  assign sel = state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      set_active <= 1'b0;
      load <= 1'b0;
    end else begin
      state <= state_nx;
      set_active <= state_nx != RUN;
      load <= state == SET_S && mode_p;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {set_h_tens, set_h_ones, set_m_tens, set_m_ones, set_s_tens, set_s_ones} <= '0;
    end else if (state == RUN && mode_p) begin
      {set_h_tens, set_h_ones, set_m_tens, set_m_ones, set_s_tens, set_s_ones} <=
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones, cur_s_tens, cur_s_ones};
    end else if (inc_ok) begin
      if (state == SET_H) {set_h_tens, set_h_ones} <= bcd_inc(set_h_tens, set_h_ones, HOURS_MAX);
      if (state == SET_M) {set_m_tens, set_m_ones} <= bcd_inc(set_m_tens, set_m_ones, MIN_SEC_MAX);
      if (state == SET_S) {set_s_tens, set_s_ones} <= bcd_inc(set_s_tens, set_s_ones, MIN_SEC_MAX);
    end
  end
  // Blink phase restarts on every field change and is held off in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      blink <= 1'b0;
    end else if (state_nx == RUN || state_nx != state) begin
      bcnt <= '0;
      blink <= 1'b0;
    end else if (bcnt == BW'(BL_CYC - 1)) begin
      bcnt <= '0;
      blink <= ~blink;
    end else bcnt <= bcnt + BW'(1);
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of debounce, set FSM, BCD increments, load strobe and blink
module tb_clock_set_ctrl;
  logic clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [23:0] cur = '0;
  logic [3:0] sht, sho, smt, smo, sst, sso;
  logic load, set_active, blink;
  logic [1:0] sel, sel_prev = 2'd0;
  int n_tests = 0, n_fail = 0, n_load = 0, n_sel = 0;
  logic [23:0] load_val = '0;
  wire [23:0] shadow = {sht, sho, smt, smo, sst, sso};
  clock_set_ctrl #(.INPUT_HZ(10_000), .DEBOUNCE_MS(1), .BLINK_HZ(500)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h_tens(cur[23:20]), .cur_h_ones(cur[19:16]), .cur_m_tens(cur[15:12]),
    .cur_m_ones(cur[11:8]), .cur_s_tens(cur[7:4]), .cur_s_ones(cur[3:0]),
    .set_h_tens(sht), .set_h_ones(sho), .set_m_tens(smt), .set_m_ones(smo),
    .set_s_tens(sst), .set_s_ones(sso), .load(load), .set_active(set_active),
    .sel(sel), .blink(blink)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (load) begin
      n_load++;
      load_val = shadow;
    end
    if (sel != sel_prev) n_sel++;
    sel_prev = sel;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc = i;
    repeat (16) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (16) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int ld0, ns0, per;
    do_reset();
    check("reset_shadow", {8'h0, shadow}, 32'h0);
    check("reset_outs", {load, set_active, sel, blink}, 5'b0);
    // Capture and load
    cur = 24'h123456;
    press(1, 0);
    check("cap_sel1", sel, 1);
    check("cap_active", set_active, 1);
    check("cap_shadow", shadow, 24'h123456);
    press(1, 0);
    check("cap_sel2", sel, 2);
    press(1, 0);
    check("cap_sel3", sel, 3);
    check("cap_noload", n_load, 0);
    press(1, 0);
    check("cap_sel0", sel, 0);
    check("cap_active0", set_active, 0);
    check("cap_load1", n_load, 1);
    check("cap_loadval", load_val, 24'h123456);
    check("cap_hold", shadow, 24'h123456);
    // Inc ignored in RUN
    press(0, 1);
    check("run_inc", shadow, 24'h123456);
    // Wrap
    cur = 24'h235959;
    press(1, 0);
    press(0, 1);
    check("wrap_h", shadow, 24'h005959);
    press(1, 0);
    press(0, 1);
    check("wrap_m", shadow, 24'h000059);
    press(1, 0);
    repeat (3) press(0, 1);
    check("wrap_s", shadow, 24'h000002);
    press(1, 0);
    check("wrap_load", n_load, 2);
    check("wrap_loadval", load_val, 24'h000002);
    // Digit carries
    cur = 24'h090930;
    press(1, 0);
    press(0, 1);
    check("carry_h09", shadow, 24'h100930);
    repeat (9) press(0, 1);
    check("carry_h19a", shadow, 24'h190930);
    press(0, 1);
    check("carry_h19", shadow, 24'h200930);
    press(1, 0);
    press(0, 1);
    check("carry_m09", shadow, 24'h201030);
    press(1, 0);
    press(1, 0);
    check("carry_load", load_val, 24'h201030);
    // Collision and blink
    cur = 24'h080000;
    press(1, 0);
    press(1, 1);
    check("coll_sel", sel, 2);
    check("coll_shadow", shadow, 24'h080000);
    per = 0;
    for (int k = 0; k < 100 && !(blink && per == 1); k++) begin
      if (per == 0 && !blink) per = 1;
      @(negedge clk);
    end
    check("blink_rise", blink, 1);
    per = 0;
    for (int k = 0; k < 100 && blink; k++) begin @(negedge clk); per++; end
    check("blink_high", per, 10);
    per = 0;
    for (int k = 0; k < 100 && !blink; k++) begin @(negedge clk); per++; end
    check("blink_low", per, 10);
    press(1, 0);
    press(1, 0);
    check("blink_run_sel", sel, 0);
    per = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); per += blink; end
    check("blink_run", per, 0);
    // Bounce
    do_reset();
    ns0 = n_sel;
    for (int k = 0; k < 10; k++) begin
      btn_mode = ~btn_mode;
      repeat (3) @(negedge clk);
    end
    btn_mode = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_early", sel, 0);
    repeat (2) @(negedge clk);
    check("bounce_sel", sel, 1);
    repeat (30) @(negedge clk);
    btn_mode = 1'b0;
    repeat (16) @(negedge clk);
    check("bounce_once", n_sel - ns0, 1);
    // Reset mid-SET_M
    press(1, 0);
    check("rst_pre", sel, 2);
    ld0 = n_load;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {load, set_active, sel, blink}, 5'b0);
    check("rst_shadow", shadow, 24'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_noload", n_load, ld0);
    check("rst_sel", sel, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
